// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from gate primitives; the single arithmetic cell of
// the bit-serial adder.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  wire p;
  wire g;
  wire t;

  xor g_p  (p, a, b);
  xor g_s  (s, p, ci);
  and g_g  (g, a, b);
  and g_t  (t, p, ci);
  or  g_co (co, g, t);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one full-adder bit per clock with a start/busy/done
// handshake. The sum is gated by the captured enable; carry-out is never gated.
module serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             E,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic             e_q, e_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

  logic             fa_s;
  logic             fa_co;
  logic             last_bit;
  logic [WIDTH-1:0] sum_next;

  full_adder_bit u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign sum_next = {fa_s, sum_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    e_d      = e_q;
    s_d      = s_q;
    cout_d   = cout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new request just like IDLE, giving back-to-back ops.
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          e_d      = E;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_next;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = ST_DONE;
          s_d     = e_q ? sum_next : '0;
          cout_d  = fa_co;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      e_q      <= 1'b0;
      s_q      <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      e_q      <= e_d;
      s_q      <= s_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver queues expected results at each
// accepted start, and a monitor checks them whenever done pulses.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         E;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .E     (E),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  exp_t         e_pop;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] hold_s = '0;
  logic         hold_c = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compares on every done pulse, and checks that s/cout hold otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_s = '0;
      hold_c = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e_pop = sb.pop_front();
        chk("sum", int'(s), int'(e_pop.s));
        chk("cout", int'(cout), int'(e_pop.c));
        chk("latency", cyc - e_pop.acc, W);
      end
      hold_s = s;
      hold_c = cout;
    end else begin
      chk("hold_s", int'(s), int'(hold_s));
      chk("hold_cout", int'(cout), int'(hold_c));
    end
  end

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      chk({nm, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                    input logic te, input logic [W-1:0] xs, input logic xc, input string nm);
    @(posedge clk); #1;
    a = ta; b = tb; cin = tc; E = te; start = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{s: xs, c: xc, acc: cyc});
    start = 1'b0;
    chk({nm, "_busy"}, int'(busy), 1);
    chk({nm, "_done_low"}, int'(done), 0);
    wait_drain(nm);
  endtask

  logic [W:0] ref_sum;
  logic       ref_e;

  initial begin
    rst_n = 1'b0; start = 1'b1; E = 1'b1; a = 4'hA; b = 4'h5; cin = 1'b1;

    // Reset with start asserted: reset must win.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_s", int'(s), 0);
    chk("rst_cout", int'(cout), 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", int'(busy), 0);

    op(4'h3, 4'h5, 1'b0, 1'b1, 4'h8, 1'b0, "add_3_5");
    op(4'hF, 4'h1, 1'b1, 1'b1, 4'h1, 1'b1, "add_f_1_c");
    op(4'hF, 4'hF, 1'b1, 1'b1, 4'hF, 1'b1, "add_f_f_c");
    op(4'h9, 4'h9, 1'b0, 1'b0, 4'h0, 1'b1, "gated_9_9");

    // Start held high: back-to-back ops through DONE; mid-RUN input changes ignored.
    @(posedge clk); #1;
    a = 4'h1; b = 4'h1; cin = 1'b0; E = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{s: 4'h2, c: 1'b0, acc: cyc});
    a = 4'h2; b = 4'h2;
    repeat (5) @(posedge clk);
    #1;
    sb.push_back('{s: 4'h4, c: 1'b0, acc: cyc});
    a = 4'h3; b = 4'h3;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain("b2b");

    // Reset during the second RUN cycle aborts the op with no done pulse.
    @(posedge clk); #1;
    a = 4'h7; b = 4'h7; cin = 1'b0; E = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_s", int'(s), 0);
    chk("abort_cout", int'(cout), 0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Exhaustive sweep against integer reference, enable varied across ops.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          ref_sum = 5'(ia) + 5'(ib) + 5'(ic);
          ref_e   = ((ia + ib + ic) % 3) != 0;
          op(4'(ia), 4'(ib), ic[0], ref_e, ref_e ? ref_sum[W-1:0] : 4'h0,
             ref_sum[W], "sweep");
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
